// File: rtl/fpu_pkg.sv
// Shared single-precision field positions, operation codes and statistics width
// for the FPU sharing fabric.
package fpu_pkg;
  localparam int SP_SIGN   = 31;
  localparam int SP_EXP_HI = 30;
  localparam int SP_EXP_LO = 23;
  localparam int SP_MAN_HI = 22;
  localparam int SP_MAN_LO = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int STAT_W = 16;

  function automatic logic [31:0] sp_neg(input logic [31:0] x);
    return {~x[SP_SIGN], x[SP_SIGN-1:0]};
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);
  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end
    end
  end
endmodule

// File: rtl/sradd.sv
// Single-precision magnitude adder for operands of equal sign (truncating,
// denormals flushed to zero).
module sradd import fpu_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);
  logic [7:0]  ea, eb, eg, shift;
  logic [23:0] mg, ms, ms_sh;
  logic [24:0] sum;
  logic        sgn;

  always_comb begin
    ea = a[SP_EXP_HI:SP_EXP_LO];
    eb = b[SP_EXP_HI:SP_EXP_LO];
    if (a[30:0] >= b[30:0]) begin
      eg = ea; shift = ea - eb; sgn = a[SP_SIGN];
      mg = {ea != 8'd0, a[SP_MAN_HI:SP_MAN_LO]};
      ms = {eb != 8'd0, b[SP_MAN_HI:SP_MAN_LO]};
    end else begin
      eg = eb; shift = eb - ea; sgn = b[SP_SIGN];
      mg = {eb != 8'd0, b[SP_MAN_HI:SP_MAN_LO]};
      ms = {ea != 8'd0, a[SP_MAN_HI:SP_MAN_LO]};
    end
    ms_sh = (shift > 8'd23) ? 24'd0 : (ms >> shift);
    sum   = {1'b0, mg} + {1'b0, ms_sh};
    z     = {sgn, 31'd0};
    if (sum[24])      z = {sgn, eg + 8'd1, sum[23:1]};
    else if (sum[23]) z = {sgn, eg, sum[22:0]};
  end
endmodule

// File: rtl/srsub.sv
// Single-precision magnitude subtractor a-b for operands of equal sign
// (truncating, underflow flushed to +0).
module srsub import fpu_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);
  logic [7:0]  ea, eb, eg, shift;
  logic [23:0] mg, ms, ms_sh, d;
  logic [22:0] norm;
  logic [4:0]  lz;
  logic        sgn;

  always_comb begin
    ea = a[SP_EXP_HI:SP_EXP_LO];
    eb = b[SP_EXP_HI:SP_EXP_LO];
    if (a[30:0] >= b[30:0]) begin
      eg = ea; shift = ea - eb; sgn = a[SP_SIGN];
      mg = {ea != 8'd0, a[SP_MAN_HI:SP_MAN_LO]};
      ms = {eb != 8'd0, b[SP_MAN_HI:SP_MAN_LO]};
    end else begin
      eg = eb; shift = eb - ea; sgn = ~b[SP_SIGN];
      mg = {eb != 8'd0, b[SP_MAN_HI:SP_MAN_LO]};
      ms = {ea != 8'd0, a[SP_MAN_HI:SP_MAN_LO]};
    end
    ms_sh = (shift > 8'd23) ? 24'd0 : (ms >> shift);
    d     = mg - ms_sh;
    lz    = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (d[i]) lz = 5'(23 - i);
    end
    // The leading one drops out of the 23-bit shift, leaving the fraction.
    norm = d[22:0] << lz;
    z    = 32'd0;
    if (d != 24'd0 && {3'b000, lz} < eg) z = {sgn, eg - {3'b000, lz}, norm};
  end
endmodule

// File: rtl/fpu_share_arb.sv
// Round-robin sharing of one add/subtract datapath among N_REQ requesters,
// two-stage registered pipeline. Optional statistics: FPU_ARB_STATS_EN.
module fpu_share_arb import fpu_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 4,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0]       req_op,
  input  logic [N_REQ*32-1:0]    req_a,
  input  logic [N_REQ*32-1:0]    req_b,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_z,
  output logic [SRC_W-1:0]       rsp_src,
`ifdef FPU_ARB_STATS_EN
  output logic [N_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]       stat_stall,
`endif
  output logic [TAG_W-1:0]       rsp_tag
);
  // Handshakes: a transfer happens on the rising edge where valid & ready are
  // both high; ready never depends on the same-side valid being low, and a
  // producer keeps its payload stable while valid is high and ready low.
  logic [SRC_W-1:0] rr_ptr, win_idx;
  logic [N_REQ-1:0] win;
  logic             s1_adv, s1_load, accept;
  logic             s1_valid, s1_op;
  logic [31:0]      s1_a, s1_b, b_mod, add_z, sub_z, disp_z;
  logic [SRC_W-1:0] s1_src;
  logic [TAG_W-1:0] s1_tag;
  logic             same, use_sub;

  rr_pick #(.N(N_REQ), .W(SRC_W)) u_pick (
    .req(req_valid), .ptr(rr_ptr), .gnt(win), .gnt_idx(win_idx)
  );

  assign s1_adv    = s1_valid & (~rsp_valid | rsp_ready);
  assign s1_load   = ~s1_valid | s1_adv;
  assign req_ready = win & {N_REQ{rst_n & s1_load}};
  assign accept    = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_op    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_src   <= '0;
      s1_tag   <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + SRC_W'(1);
      end
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_op  <= req_op[win_idx];
          s1_a   <= req_a[int'(win_idx)*32 +: 32];
          s1_b   <= req_b[int'(win_idx)*32 +: 32];
          s1_src <= win_idx;
          s1_tag <= req_tag[int'(win_idx)*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Opposite-sign operands flip b's sign so each unit only sees equal signs.
  assign same    = s1_a[SP_SIGN] == s1_b[SP_SIGN];
  assign b_mod   = same ? s1_b : sp_neg(s1_b);
  assign use_sub = (s1_op == OP_ADD) ? ~same : same;

  srsub u_srsub (.a(s1_a), .b(b_mod), .z(sub_z));
  sradd u_sradd (.a(s1_a), .b(b_mod), .z(add_z));

  assign disp_z = use_sub ? sub_z : add_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_src   <= '0;
      rsp_tag   <= '0;
    end else if (s1_adv) begin
      rsp_valid <= 1'b1;
      rsp_z     <= disp_z;
      rsp_src   <= s1_src;
      rsp_tag   <= s1_tag;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [N_REQ];
  logic [STAT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && grant_cnt[i] != '1)
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if (rsp_valid && !rsp_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
  end
  assign stat_stall = stall_cnt;
`endif
endmodule

// File: tb/tb_fpu_share_arb.sv
// Bench for fpu_share_arb: directed vectors, a real-arithmetic reference model
// with a response queue, and a per-cycle compare process.
module tb_fpu_share_arb;
  import fpu_pkg::*;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int SW = 2;
  localparam int EW = 32 + SW + TW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_op = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_z;
  logic [SW-1:0]   rsp_src;
  logic [TW-1:0]   rsp_tag;
`ifdef FPU_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stall;
`endif

  fpu_share_arb #(.N_REQ(N), .TAG_W(TW), .SRC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_src(rsp_src),
`ifdef FPU_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_stall(stat_stall),
`endif
    .rsp_tag(rsp_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real sp2r(input logic [31:0] x);
    real m;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] model_z(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    return r2sp(op == OP_SUB ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
  endfunction

  logic [EW-1:0] exp_q[$];
  int            age_q[$];
  int            got_src_q[$];
  int            ncyc = 0;
  int            mptr = 0;
  int            m_w, m_idx;
  logic [N-1:0]  exp_rdy;
  logic          exp_v;
  logic [EW-1:0] e_item;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      age_q.delete();
      mptr = 0;
    end else begin
      ncyc++;
      m_w = -1;
      for (int k = 0; k < N; k++) begin
        m_idx = (mptr + k) % N;
        if (m_w < 0 && req_valid[m_idx]) m_w = m_idx;
      end
      exp_rdy = '0;
      if (m_w >= 0 && (exp_q.size() < 2 || rsp_ready)) exp_rdy[m_w] = 1'b1;
      check(req_ready == exp_rdy, "req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_v = (exp_q.size() > 0) && (ncyc - age_q[0] >= 2);
      check(rsp_valid == exp_v, "rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v && rsp_ready) begin
        e_item = exp_q.pop_front();
        void'(age_q.pop_front());
        check(rsp_z == e_item[31:0], "rsp_z", rsp_z, e_item[31:0]);
        check(rsp_tag == e_item[32 +: TW], "rsp_tag", 32'(rsp_tag), 32'(e_item[32 +: TW]));
        check(rsp_src == e_item[32+TW +: SW], "rsp_src", 32'(rsp_src),
              32'(e_item[32+TW +: SW]));
        got_src_q.push_back(int'(rsp_src));
      end
      if (|exp_rdy) begin
        exp_q.push_back({SW'(m_w), req_tag[m_w*TW +: TW],
                         model_z(req_a[m_w*32 +: 32], req_b[m_w*32 +: 32], req_op[m_w])});
        age_q.push_back(ncyc);
        mptr = (m_w + 1) % N;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_req(input int i, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TW-1:0] tag);
    req_valid[i]        = 1'b1;
    req_op[i]           = op;
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
    req_tag[i*TW +: TW] = tag;
  endtask

  task automatic wait_accept(input int i);
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (req_ready[i] && req_valid[i]) got = 1'b1;
      n++;
    end
    check(got, "accept_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_one(input int i, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TW-1:0] tag,
                        input logic [31:0] exp_z, input string name);
    set_req(i, op, a, b, tag);
    wait_accept(i);
    repeat (2) @(negedge clk);
    check(rsp_valid == 1'b1, "do_one_valid", 32'(rsp_valid), 32'd1);
    check(rsp_z == exp_z, name, rsp_z, exp_z);
    check(rsp_src == SW'(i), "do_one_src", 32'(rsp_src), 32'(i));
    idle(1);
  endtask

  task automatic set_all;
    set_req(0, OP_ADD, 32'h40400000, 32'h3F800000, 4'd8);
    set_req(1, OP_ADD, 32'hC0000000, 32'h3F800000, 4'd9);
    set_req(2, OP_SUB, 32'h40A00000, 32'h40400000, 4'd10);
    set_req(3, OP_SUB, 32'h3F000000, 32'hC0000000, 4'd11);
  endtask

  int order [8];

  initial begin
    // reset values, ready held low while in reset
    idle(2);
    check(rsp_valid == 1'b0, "rst_valid", 32'(rsp_valid), 32'd0);
    check(rsp_z == 32'd0, "rst_z", rsp_z, 32'd0);
    check(rsp_src == '0, "rst_src", 32'(rsp_src), 32'd0);
    check(rsp_tag == '0, "rst_tag", 32'(rsp_tag), 32'd0);
    req_valid = 4'b0101;
    #1;
    check(req_ready == 4'b0000, "rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
`ifdef FPU_ARB_STATS_EN
    check(stat_grants == '0 && stat_stall == '0, "rst_stats", 32'(stat_stall), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // sub, same sign, with latency check
    set_req(0, OP_SUB, 32'h40000000, 32'h3F800000, 4'd5);
    wait_accept(0);
    @(negedge clk);
    check(rsp_valid == 1'b0, "lat_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check(rsp_valid == 1'b1, "lat_valid", 32'(rsp_valid), 32'd1);
    check(rsp_z == 32'h3F800000, "sub_same", rsp_z, 32'h3F800000);
    check(rsp_src == 2'd0, "sub_same_src", 32'(rsp_src), 32'd0);
    check(rsp_tag == 4'd5, "sub_same_tag", 32'(rsp_tag), 32'd5);
    idle(2);

    do_one(1, OP_SUB, 32'h3F800000, 32'hBF800000, 4'd1, 32'h40000000, "sub_opp");
    do_one(2, OP_ADD, 32'h3F800000, 32'h3F800000, 4'd2, 32'h40000000, "add_same");
    do_one(3, OP_SUB, 32'h3F800000, 32'h3F800000, 4'd3, 32'h00000000, "sub_equal");
    do_one(0, OP_ADD, 32'hC0000000, 32'h3F800000, 4'd4, 32'hBF800000, "add_opp");
    do_one(1, OP_SUB, 32'h3F000000, 32'hC0000000, 4'd6, 32'h40200000, "sub_opp_frac");

    // fairness from a fresh pointer
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    got_src_q.delete();
    set_all();
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      order[g] = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) order[g] = i;
    end
    @(posedge clk); #1;
    req_valid = '0;
    idle(4);
    for (int g = 0; g < 8; g++) check(order[g] == g % 4, "fair_grant", 32'(order[g]), 32'(g % 4));
    check(got_src_q.size() == 8, "fair_count", 32'(got_src_q.size()), 32'd8);
    for (int g = 0; g < 8 && g < got_src_q.size(); g++)
      check(got_src_q[g] == g % 4, "fair_rsp_src", 32'(got_src_q[g]), 32'(g % 4));

    // backpressure: fill both stages, hold, release
    got_src_q.delete();
    rsp_ready = 1'b0;
    set_all();
    repeat (2) @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      check(req_ready == 4'b0000, "bp_ready", 32'(req_ready), 32'd0);
      check(rsp_valid == 1'b1, "bp_valid", 32'(rsp_valid), 32'd1);
      check(rsp_z == 32'h40800000, "bp_hold_z", rsp_z, 32'h40800000);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    idle(5);
    check(got_src_q.size() == 6, "bp_count", 32'(got_src_q.size()), 32'd6);
    for (int g = 0; g < 6 && g < got_src_q.size(); g++)
      check(got_src_q[g] == g % 4, "bp_rsp_src", 32'(got_src_q[g]), 32'(g % 4));

    // reset with both stages full
    rsp_ready = 1'b0;
    set_all();
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check(rsp_valid == 1'b0, "mid_rst_valid", 32'(rsp_valid), 32'd0);
    check(rsp_z == 32'd0, "mid_rst_z", rsp_z, 32'd0);
    check(req_ready == 4'b0000, "mid_rst_ready", 32'(req_ready), 32'd0);
`ifdef FPU_ARB_STATS_EN
    check(stat_grants == '0 && stat_stall == '0, "mid_rst_stats", 32'(stat_stall), 32'd0);
`endif
    @(posedge clk); #1;
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    check(req_ready == 4'b0010, "first_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    idle(5);

    check(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
